// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side bus of dmem_arbiter, grouped so the
// arbiter sees one slave port and the requesters/memory one master port.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
) ();

   logic [1:0]        req;
   logic [1:0]        we;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic [1:0]        gnt;
   logic [1:0]        done;
   logic              err;
   logic [DATA_W-1:0] rdata;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_read_data;

   modport slave (
      input  req, we, addr0, addr1, wdata0, wdata1, mem_read_data,
      output gnt, done, err, rdata, mem_read, mem_write, mem_address, mem_write_data
   );

   modport master (
      output req, we, addr0, addr1, wdata0, wdata1, mem_read_data,
      input  gnt, done, err, rdata, mem_read, mem_write, mem_address, mem_write_data
   );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of the single-ported data memory:
// one transaction at a time, misaligned doubleword accesses are rejected.
module dmem_arbiter #(
   parameter int unsigned ADDR_W     = 64,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned RD_LAT     = 0,
   parameter int unsigned FIXED_PRIO = 0
) (
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus_io
);

   localparam int unsigned CntW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);
   localparam logic [CntW-1:0] LastCnt = CntW'((RD_LAT > 0) ? RD_LAT - 1 : 0);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic              sel_q, sel_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        done_q, done_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;

   logic              win;
   logic [1:0]        win_oh;
   logic [1:0]        sel_oh;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   // Tie-break: fixed priority favours port 0, round-robin favours the port that lost last time.
   always_comb begin
      win = 1'b0;
      case (bus_io.req)
         2'b10:   win = 1'b1;
         2'b11:   win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
         default: win = 1'b0;
      endcase
   end

   assign win_oh    = win ? 2'b10 : 2'b01;
   assign sel_oh    = sel_q ? 2'b10 : 2'b01;
   assign win_we    = win ? bus_io.we[1] : bus_io.we[0];
   assign win_addr  = win ? bus_io.addr1 : bus_io.addr0;
   assign win_wdata = win ? bus_io.wdata1 : bus_io.wdata0;

   // Outputs are computed for the state being entered so they come straight from flops.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      sel_d       = sel_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      gnt_d       = 2'b00;
      done_d      = 2'b00;
      err_d       = 1'b0;
      rdata_d     = rdata_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus_io.req != 2'b00) begin
               sel_d   = win;
               last_d  = win;
               we_d    = win_we;
               addr_d  = win_addr;
               wdata_d = win_wdata;
               if (win_addr[2:0] != 3'b000) begin
                  state_d = StResp;
                  done_d  = win_oh;
                  err_d   = 1'b1;
               end else begin
                  state_d     = StIssue;
                  gnt_d       = win_oh;
                  mem_write_d = win_we;
                  mem_read_d  = ~win_we;
               end
            end
         end

         StIssue: begin
            if (we_q) begin
               state_d = StResp;
               done_d  = sel_oh;
            end else if (RD_LAT == 0) begin
               state_d = StResp;
               done_d  = sel_oh;
               rdata_d = bus_io.mem_read_data;
            end else begin
               state_d    = StWait;
               cnt_d      = '0;
               mem_read_d = 1'b1;
            end
         end

         StWait: begin
            if (cnt_q == LastCnt) begin
               state_d = StResp;
               done_d  = sel_oh;
               rdata_d = bus_io.mem_read_data;
            end else begin
               cnt_d      = cnt_q + CntW'(1);
               mem_read_d = 1'b1;
            end
         end

         StResp: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         last_q      <= 1'b1;
         sel_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         gnt_q       <= 2'b00;
         done_q      <= 2'b00;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         sel_q       <= sel_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
      end
   end

   // The latched command doubles as the memory address/data bus; only the strobes qualify it.
   assign bus_io.gnt            = gnt_q;
   assign bus_io.done           = done_q;
   assign bus_io.err            = err_q;
   assign bus_io.rdata          = rdata_q;
   assign bus_io.mem_read       = mem_read_q;
   assign bus_io.mem_write      = mem_write_q;
   assign bus_io.mem_address    = addr_q;
   assign bus_io.mem_write_data = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: three configurations run side by side,
// each with its own memory model, reference model, driver and monitor.
module tb_dmem_arbiter;

   typedef struct {
      bit [1:0]    req;
      bit [1:0]    we;
      logic [63:0] a0;
      logic [63:0] a1;
      logic [63:0] w0;
      logic [63:0] w1;
      bit          hold;
      int          gap;
      bit          rst_mid;
   } round_t;

   typedef struct {
      int          port;
      bit          we;
      bit          err;
      logic [63:0] addr;
      logic [63:0] data;
      int          cyc;
      int          strobes;
   } exp_t;

   localparam int NumDir  = 15;
   localparam int NumRand = 120;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int env, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL env%0d %s: got 0x%0h, required 0x%0h (cycle %0d)", env, name, act, exp,
                  cyc);
      end
   endtask

   function automatic round_t dir_round(input int i);
      round_t r;
      r.req = 2'b00; r.we = 2'b00; r.a0 = '0; r.a1 = '0; r.w0 = '0; r.w1 = '0;
      r.hold = 1'b0; r.gap = 0; r.rst_mid = 1'b0;
      case (i)
         0: begin r.req = 2'b01; r.we = 2'b01; r.a0 = 64'h10; r.w0 = 64'hDEADBEEFCAFEBABE; end
         1: begin r.req = 2'b01; r.a0 = 64'h10; end
         2: begin r.req = 2'b10; r.we = 2'b10; r.a1 = 64'h20; r.w1 = 64'h123456789ABCDEF0; end
         3: begin r.req = 2'b10; r.a1 = 64'h20; end
         4: begin r.req = 2'b01; r.a0 = 64'h13; end
         5, 6, 7, 8: begin r.req = 2'b11; r.a0 = 64'h10; r.a1 = 64'h20; end
         9, 10, 11, 12: begin
            r.req = 2'b10; r.we = 2'b10; r.hold = 1'b1;
            r.a1 = 64'(40 + 8 * (i - 9));
            r.w1 = 64'hA5A5_0000_0000_0000 | 64'(i);
         end
         13: begin r.req = 2'b01; r.a0 = 64'h10; r.rst_mid = 1'b1; end
         14: begin r.req = 2'b11; r.a0 = 64'h20; r.a1 = 64'h10; end
         default: ;
      endcase
      return r;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_env
      localparam int unsigned RL = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
      localparam int unsigned FP = (g == 2) ? 1 : 0;

      logic        rst;
      bit          fin = 1'b0;
      bit [63:0]   dm [16];
      int          rd_age = 0;
      exp_t        gq[$];
      exp_t        dq[$];
      bit [63:0]   mdl_mem [16];
      bit          mdl_last;
      logic [63:0] mdl_rdata;
      int          st_run = 0;
      exp_t        me;

      dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ifc ();

      dmem_arbiter #(
         .ADDR_W(64),
         .DATA_W(64),
         .RD_LAT(RL),
         .FIXED_PRIO(FP)
      ) u_dut (
         .clk(clk),
         .reset(rst),
         .bus_io(ifc)
      );

      // Data memory: read data is garbage until the strobe has been held RL cycles.
      always @(posedge clk) begin
         if (ifc.mem_write) dm[ifc.mem_address[6:3]] <= ifc.mem_write_data;
         rd_age <= ifc.mem_read ? rd_age + 1 : 0;
      end
      assign ifc.mem_read_data = (ifc.mem_read && rd_age >= int'(RL)) ?
                                 dm[ifc.mem_address[6:3]] : 64'hBAD0_BAD0_BAD0_BAD0;

      always @(negedge clk) begin
         if (rst) begin
            st_run = 0;
         end else begin
            if (ifc.mem_read || ifc.mem_write) begin
               chk("strobe_exclusive", g, 64'(ifc.mem_read & ifc.mem_write), 64'd0);
               st_run++;
            end
            if (ifc.gnt != 2'b00) begin
               if (gq.size() == 0) begin
                  chk("unexpected_gnt", g, 64'(ifc.gnt), 64'd0);
               end else begin
                  me = gq.pop_front();
                  chk("gnt_port", g, 64'(ifc.gnt), 64'(2'b01 << me.port));
                  chk("gnt_cycle", g, 64'(cyc), 64'(me.cyc));
                  chk("gnt_mem_write", g, 64'(ifc.mem_write), 64'(me.we));
                  chk("gnt_mem_read", g, 64'(ifc.mem_read), 64'(!me.we));
                  chk("gnt_mem_address", g, ifc.mem_address, me.addr);
                  if (me.we) chk("gnt_mem_write_data", g, ifc.mem_write_data, me.data);
               end
            end
            if (ifc.done != 2'b00) begin
               if (dq.size() == 0) begin
                  chk("unexpected_done", g, 64'(ifc.done), 64'd0);
               end else begin
                  me = dq.pop_front();
                  chk("done_port", g, 64'(ifc.done), 64'(2'b01 << me.port));
                  chk("done_cycle", g, 64'(cyc), 64'(me.cyc));
                  chk("done_err", g, 64'(ifc.err), 64'(me.err));
                  chk("done_rdata", g, ifc.rdata, me.data);
                  chk("strobe_cycles", g, 64'(st_run), 64'(me.strobes));
               end
               st_run = 0;
            end
         end
      end

      initial begin
         round_t      r;
         exp_t        e;
         bit          w;
         bit          wwe;
         int          lat;
         logic [63:0] a;
         logic [63:0] wd;

         rst = 1'b1;
         ifc.req = 2'b00; ifc.we = 2'b00;
         ifc.addr0 = '0; ifc.addr1 = '0; ifc.wdata0 = '0; ifc.wdata1 = '0;
         mdl_last = 1'b1;
         mdl_rdata = '0;
         repeat (2) @(posedge clk);
         #1;
         chk("reset_ctrl", g, 64'({ifc.gnt, ifc.done, ifc.err, ifc.mem_read, ifc.mem_write}), 0);
         chk("reset_rdata", g, ifc.rdata, 64'd0);
         chk("reset_mem_address", g, ifc.mem_address, 64'd0);
         chk("reset_mem_write_data", g, ifc.mem_write_data, 64'd0);
         rst = 1'b0;
         @(posedge clk);
         #1;

         for (int i = 0; i < NumDir + NumRand; i++) begin
            if (i < NumDir) begin
               r = dir_round(i);
            end else begin
               r.req = 2'($urandom_range(1, 3));
               r.we  = 2'($urandom_range(0, 3));
               r.a0  = 64'($urandom_range(0, 15)) << 3;
               r.a1  = 64'($urandom_range(0, 15)) << 3;
               if ($urandom_range(0, 7) == 0) r.a0[2:0] = 3'($urandom_range(1, 7));
               if ($urandom_range(0, 7) == 0) r.a1[2:0] = 3'($urandom_range(1, 7));
               r.w0 = {$urandom, $urandom};
               r.w1 = {$urandom, $urandom};
               r.hold = 1'b0;
               r.rst_mid = 1'b0;
               r.gap = $urandom_range(0, 2);
            end

            ifc.req = r.req; ifc.we = r.we;
            ifc.addr0 = r.a0; ifc.addr1 = r.a1; ifc.wdata0 = r.w0; ifc.wdata1 = r.w1;

            // Reference model: who wins, what memory holds, when the responses appear.
            if (r.req == 2'b01) w = 1'b0;
            else if (r.req == 2'b10) w = 1'b1;
            else if (FP != 0) w = 1'b0;
            else w = ~mdl_last;
            mdl_last = w;
            a   = w ? r.a1 : r.a0;
            wwe = w ? r.we[1] : r.we[0];
            wd  = w ? r.w1 : r.w0;
            if (a[2:0] != 3'b000) begin
               lat = 1;
               e = '{port: int'(w), we: wwe, err: 1'b1, addr: a, data: mdl_rdata,
                     cyc: cyc + 1, strobes: 0};
               dq.push_back(e);
            end else begin
               e = '{port: int'(w), we: wwe, err: 1'b0, addr: a, data: wd,
                     cyc: cyc + 1, strobes: 0};
               gq.push_back(e);
               if (wwe) begin
                  mdl_mem[a[6:3]] = wd;
                  lat = 2;
               end else begin
                  mdl_rdata = mdl_mem[a[6:3]];
                  lat = 2 + int'(RL);
               end
               e = '{port: int'(w), we: wwe, err: 1'b0, addr: a, data: mdl_rdata,
                     cyc: cyc + lat, strobes: wwe ? 1 : 1 + int'(RL)};
               if (!r.rst_mid) dq.push_back(e);
            end

            if (r.rst_mid) begin
               @(posedge clk);
               #1;
               ifc.req = 2'b00;
               if (RL > 0) begin
                  @(posedge clk);
                  #1;
               end
               #2;
               rst = 1'b1;
               gq.delete();
               dq.delete();
               #1;
               chk("midrst_ctrl", g,
                   64'({ifc.gnt, ifc.done, ifc.err, ifc.mem_read, ifc.mem_write}), 0);
               chk("midrst_rdata", g, ifc.rdata, 64'd0);
               chk("midrst_mem_address", g, ifc.mem_address, 64'd0);
               chk("midrst_mem_write_data", g, ifc.mem_write_data, 64'd0);
               mdl_last = 1'b1;
               mdl_rdata = '0;
               repeat (2) @(posedge clk);
               #1;
               rst = 1'b0;
               @(posedge clk);
               #1;
            end else begin
               for (int k = 1; k <= lat; k++) begin
                  @(posedge clk);
                  #1;
                  if (k == 1 && !r.hold) ifc.req = 2'b00;
               end
               repeat (r.gap + 1) begin
                  @(posedge clk);
                  #1;
               end
            end
         end

         for (int k = 0; k < 30 && (gq.size() != 0 || dq.size() != 0); k++) @(posedge clk);
         chk("queues_drained", g, 64'(gq.size() + dq.size()), 64'd0);
         fin = 1'b1;
      end
   end

   initial begin
      int guard;
      guard = 0;
      while (!(g_env[0].fin && g_env[1].fin && g_env[2].fin) && guard < 20000) begin
         @(posedge clk);
         guard++;
      end
      if (guard >= 20000) chk("global_timeout", 0, 64'(guard), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported DataMemory (clk, mem_read, mem_write, 64-bit address/write_data/read_data).
- Port 0 is the core load/store unit; port 1 is the program/data loader (debug/DMA).
- Accepts one transaction at a time, drives the memory strobes for it, waits the memory read latency, and returns read data with a completion pulse.
- Misaligned doubleword accesses are rejected without touching memory.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- RD_LAT, 0, extra cycles from read strobe until read_data is valid; 0 means combinational read.
- FIXED_PRIO, 0, arbitration mode: 0 = round-robin, 1 = port 0 always wins ties.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  per-port request; bit i belongs to port i.
- we  in  2  per-port write enable; 1 = store, 0 = load.
- addr0, addr1  in  ADDR_W  per-port byte address.
- wdata0, wdata1  in  DATA_W  per-port store data.
- gnt  out  2  one-cycle pulse: that port's command has been issued to memory.
- done  out  2  one-cycle pulse: transaction complete.
- err  out  1  valid with done; 1 = access was misaligned and not performed.
- rdata  out  DATA_W  load result; valid with done; holds its value until the next completed load.
- mem_read  out  1  to DataMemory.mem_read.
- mem_write  out  1  to DataMemory.mem_write.
- mem_address  out  ADDR_W  to DataMemory.address.
- mem_write_data  out  DATA_W  to DataMemory.write_data.
- mem_read_data  in  DATA_W  from DataMemory.read_data.

Behaviour:
- Reset (asynchronous, reset=1):
  - State returns to IDLE and the round-robin pointer last is set to 1.
  - All outputs go to 0: gnt, done, err, rdata, mem_read, mem_write, mem_address, mem_write_data.
  - Any in-flight transaction is dropped; no done is issued for it.
- State IDLE:
  - If req is nonzero, pick a winner.
  - Single requester: that requester wins.
  - Both requesting, FIXED_PRIO=1: port 0 wins.
  - Both requesting, FIXED_PRIO=0: the port not equal to last wins.
  - On the rising edge, latch the winner's we, addr and wdata; set last to the winner.
  - If addr[2:0] != 0, go to RESP with err pending; otherwise go to ISSUE.
  - If req is zero, stay in IDLE.
- State ISSUE (exactly one cycle):
  - gnt[winner] is 1.
  - mem_address and mem_write_data are driven from the latched command.
  - Store: mem_write=1; next state is RESP.
  - Load: mem_read=1; next state is WAIT if RD_LAT>0, else mem_read_data is captured into the response register and the next state is RESP.
- State WAIT (loads only):
  - Lasts RD_LAT cycles; mem_read and mem_address stay held.
  - mem_read_data is captured on the edge that ends the last WAIT cycle; the next state is RESP.
- State RESP (one cycle):
  - done[winner] is 1.
  - rdata is updated only for a successful load.
  - err is 1 only for a misaligned access.
  - Memory strobes are 0. Next state is IDLE.
- Misaligned access: gnt is never asserted, mem_read and mem_write never assert, and rdata is unchanged.
- Latency:
  - Store: gnt in cycle T+1, done in T+2, where T is the IDLE cycle that samples req.
  - Load: done in T+2+RD_LAT.
  - Minimum spacing between accepted transactions: 3+RD_LAT cycles for loads, 3 cycles for stores.
- Requester rules:
  - Hold req, we, addr and wdata stable until the cycle gnt is seen. A misaligned request is held until done instead.
  - Drop req in the cycle after gnt or done; a req still high when IDLE is re-entered is treated as a new request.
- Outside ISSUE and WAIT, mem_read and mem_write are 0; they are never both 1.
- A req seen during ISSUE, WAIT or RESP is ignored, not queued.

Test Plan:
- Port 0 store: addr 0x10, wdata 0xDEADBEEFCAFEBABE. Then port 0 load from 0x10 (RD_LAT=0). Required: gnt[0] in T+1 with mem_write=1; load done[0] with rdata=0xDEADBEEFCAFEBABE and err=0.
- Both ports request loads in the same cycle, repeatedly, FIXED_PRIO=0. Required: grants alternate 0,1,0,1. Repeat with FIXED_PRIO=1: port 0 is always granted while it requests.
- Port 1 store of 0x123456789ABCDEF0 at 0x20, then load at 0x20 with RD_LAT=2. Required: mem_read held 3 cycles; done[1] in T+4 with rdata=0x123456789ABCDEF0.
- Port 0 load at address 0x13. Required: no mem_read or gnt; done[0]=1 with err=1 at T+1; rdata unchanged.
- Assert reset during WAIT of a load. Required: all outputs 0 immediately, no done; next request arbitrates with port 0 winning a tie.
- Port 1 holds req continuously. Required: it is re-granted every 3 cycles for stores, and mem_read/mem_write are never simultaneously 1.
